// File: rtl/ram_mp_tb.sv
// Multi-channel word-addressed RAM model: CH client ports share one array through a
// round-robin arbiter with programmable read latency and post-grant busy cycles.
module ram_mp_tb #(
   parameter int unsigned AW        = 18,
   parameter int unsigned DW        = 16,
   parameter int unsigned CH        = 2,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned BUSY_CYC  = 0,
   parameter string       INIT_FILE = ""
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [CH*AW-1:0]    A,
   input  logic [CH*DW-1:0]    D,
   input  logic [CH*DW/8-1:0]  WE,
   input  logic [CH-1:0]       RD,
   output logic [CH*DW-1:0]    Q,
   output logic [CH-1:0]       RDY,
   output logic [CH-1:0]       PROTO_ERR
);

   localparam int unsigned BW  = DW / 8;
   localparam int unsigned PW  = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned SW  = (BUSY_CYC > 0) ? $clog2(BUSY_CYC + 1) : 1;
   localparam int unsigned SNW = AW + DW + BW + 1;

   typedef enum logic [1:0] {StIdle, StWait, StOut} ch_st_e;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   ch_st_e                    st_q [CH];
   ch_st_e                    st_d [CH];
   logic [SNW-1:0]            snap_q [CH];
   logic [SNW-1:0]            snap_d [CH];
   logic [SNW-1:0]            chan_in [CH];
   logic [DW-1:0]             qh_q [CH];
   logic [DW-1:0]             qh_d [CH];
   logic [CH-1:0]             req, err_q, err_d, wr_rdy_q, wr_rdy_d, gnt_oh, rd_done;
   logic [PW-1:0]             ptr_q, ptr_d, gnt_ch;
   logic [SW-1:0]             slot_q, slot_d;
   logic                      gnt_vld, gnt_found, gnt_rd;
   logic [AW-1:0]             gnt_a;
   logic [DW-1:0]             gnt_d;
   logic [BW-1:0]             gnt_we;
   logic [RD_LAT-1:0]         pv_q, pv_d;
   logic [RD_LAT-1:0][PW-1:0] pc_q, pc_d;
   logic [RD_LAT-1:0][DW-1:0] pd_q, pd_d;

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         chan_in[c] = {A[c*AW +: AW], D[c*DW +: DW], WE[c*BW +: BW], RD[c]};
         req[c]     = RD[c] | (|WE[c*BW +: BW]);
      end
   end

   // Round-robin: first eligible channel at or above ptr, else first eligible overall.
   always_comb begin
      gnt_found = 1'b0;
      gnt_ch    = '0;
      gnt_oh    = '0;
      gnt_a     = '0;
      gnt_d     = '0;
      gnt_we    = '0;
      gnt_rd    = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (!gnt_found && req[c] && st_q[c] != StOut && c >= int'(ptr_q)) begin
            gnt_found = 1'b1;
            gnt_ch    = PW'(c);
         end
      end
      for (int c = 0; c < CH; c++) begin
         if (!gnt_found && req[c] && st_q[c] != StOut) begin
            gnt_found = 1'b1;
            gnt_ch    = PW'(c);
         end
      end
      gnt_vld = gnt_found && (slot_q == '0) && RST_N;
      for (int c = 0; c < CH; c++) begin
         gnt_oh[c] = gnt_vld && (gnt_ch == PW'(c));
         if (gnt_oh[c]) begin
            gnt_a  = A[c*AW +: AW];
            gnt_d  = D[c*DW +: DW];
            gnt_we = WE[c*BW +: BW];
            gnt_rd = RD[c];
         end
      end
      ptr_d  = ptr_q;
      slot_d = slot_q;
      if (gnt_vld) begin
         ptr_d  = (gnt_ch == PW'(CH - 1)) ? '0 : gnt_ch + PW'(1);
         slot_d = SW'(BUSY_CYC);
      end else if (slot_q != '0) begin
         slot_d = slot_q - SW'(1);
      end
   end

   always_comb begin
      pv_d = '0;
      pc_d = '0;
      pd_d = '0;
      pv_d[0] = gnt_vld && gnt_rd && (gnt_we == '0);
      pc_d[0] = gnt_ch;
      pd_d[0] = mem[gnt_a];
      for (int k = 1; k < RD_LAT; k++) begin
         pv_d[k] = pv_q[k-1];
         pc_d[k] = pc_q[k-1];
         pd_d[k] = pd_q[k-1];
      end
      wr_rdy_d = gnt_vld && (gnt_we != '0) ? gnt_oh : '0;
   end

   always_comb begin
      Q = '0;
      for (int c = 0; c < CH; c++) begin
         rd_done[c] = pv_q[RD_LAT-1] && (pc_q[RD_LAT-1] == PW'(c));
         RDY[c]     = rd_done[c] | wr_rdy_q[c];
         if (rd_done[c]) begin
            qh_d[c] = pd_q[RD_LAT-1];
         end else if (wr_rdy_q[c]) begin
            qh_d[c] = '0;
         end else begin
            qh_d[c] = qh_q[c];
         end
         Q[c*DW +: DW] = qh_d[c];
      end
      PROTO_ERR = err_q;
   end

   // Snapshot tracks inputs until the channel is granted; any later change is a violation.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         st_d[c]   = st_q[c];
         snap_d[c] = snap_q[c];
         err_d[c]  = err_q[c];
         if (st_q[c] != StOut) begin
            snap_d[c] = chan_in[c];
            if (RD[c] && (WE[c*BW +: BW] != '0)) err_d[c] = 1'b1;
         end
         unique case (st_q[c])
            StIdle: begin
               if (req[c]) st_d[c] = gnt_oh[c] ? StOut : StWait;
            end
            StWait: begin
               if (chan_in[c] != snap_q[c]) err_d[c] = 1'b1;
               if (!req[c]) begin
                  st_d[c] = StIdle;
               end else if (gnt_oh[c]) begin
                  st_d[c] = StOut;
               end
            end
            StOut: begin
               if (RDY[c]) begin
                  st_d[c] = StIdle;
               end else if (chan_in[c] != snap_q[c]) begin
                  err_d[c] = 1'b1;
               end
            end
            default: st_d[c] = StIdle;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q    <= '0;
         slot_q   <= '0;
         err_q    <= '0;
         wr_rdy_q <= '0;
         pv_q     <= '0;
         pc_q     <= '0;
         pd_q     <= '0;
         for (int c = 0; c < CH; c++) begin
            st_q[c]   <= StIdle;
            snap_q[c] <= '0;
            qh_q[c]   <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         slot_q   <= slot_d;
         err_q    <= err_d;
         wr_rdy_q <= wr_rdy_d;
         pv_q     <= pv_d;
         pc_q     <= pc_d;
         pd_q     <= pd_d;
         for (int c = 0; c < CH; c++) begin
            st_q[c]   <= st_d[c];
            snap_q[c] <= snap_d[c];
            qh_q[c]   <= qh_d[c];
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int b = 0; b < BW; b++) begin
         if (gnt_vld && gnt_we[b]) mem[gnt_a][b*8 +: 8] <= gnt_d[b*8 +: 8];
      end
   end

endmodule
